// File: rtl/divfloat_batch_driver.sv
// Sequences buffered float operands through a run-style divider one at a time and stores the quotients.
// Optional per-element watchdog is compiled in with `define DIVBATCH_TIMEOUT_EN.
module divfloat_batch_driver #(
   parameter int DEPTH          = 8,
   parameter int ADDR_W         = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [31:0]       i_wr_data,
   input  logic [ADDR_W:0]   i_count,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [31:0]       o_rd_data,
   output logic              o_div_req,
   output logic [31:0]       o_div_input_a,
   input  logic              i_div_busy,
   input  logic [31:0]       i_div_return
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_DONE} state_t;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       op_mem  [DEPTH];
   logic [31:0]       res_mem [DEPTH];
   logic              start_ok, capture, last_elem, timed_out;

   assign start_ok  = (state_q == S_IDLE) && i_start;
   assign capture   = (state_q == S_WAIT_DONE) && !i_div_busy;
   assign last_elem = (({1'b0, idx_q} + (ADDR_W+1)'(1)) == cnt_q);

`ifdef DIVBATCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q;

   always_comb begin
      tmo_d = tmo_q;
      if (state_q == S_ISSUE)
         tmo_d = '0;
      else if (state_q inside {S_WAIT_ACK, S_WAIT_DONE})
         tmo_d = tmo_q + TMO_W'(1);
   end

   // A capture landing on the final allowed cycle still counts as a normal completion.
   assign timed_out = (state_q inside {S_WAIT_ACK, S_WAIT_DONE}) &&
                      (tmo_d == TMO_W'(TIMEOUT_CYCLES)) && !capture;

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else if (ce) begin
         tmo_q <= tmo_d;
         if (start_ok)
            err_q <= 1'b0;
         else if (timed_out)
            err_q <= 1'b1;
      end
   end

   assign o_error = err_q;
`else
   assign timed_out = 1'b0;
   assign o_error   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
      end else if (ce) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               cnt_d   = (i_count > DEPTH_L) ? DEPTH_L : i_count;
               idx_d   = '0;
               state_d = (cnt_d == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE:    state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (timed_out)
               state_d = S_DONE;
            else if (i_div_busy)
               state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (capture) begin
               if (last_elem) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_ISSUE;
               end
            end else if (timed_out) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Done is registered one cycle after DONE; busy drops at the end of the done pulse.
   always_comb begin
      done_d = (state_q == S_DONE);
      busy_d = busy_q;
      if (start_ok)
         busy_d = 1'b1;
      else if (done_q)
         busy_d = 1'b0;
      a_d = a_q;
      if (state_d == S_ISSUE)
         a_d = op_mem[idx_d];
   end

   always_comb begin
      o_div_req     = (state_q == S_ISSUE);
      o_busy        = busy_q;
      o_done        = done_q;
      o_div_input_a = a_q;
   end

   always_ff @(posedge clock) begin
      if (!reset && ce) begin
         if (i_wr_en && !busy_q)
            op_mem[i_wr_addr] <= i_wr_data;
         if (capture)
            res_mem[idx_q] <= i_div_return;
      end
   end

   assign o_rd_data = ({1'b0, i_rd_addr} < DEPTH_L) ? res_mem[i_rd_addr] : '0;

endmodule

// File: tb/tb_divfloat_batch_driver.sv
// Bench for divfloat_batch_driver with a behavioural divider stub and a result scoreboard.
module tb_divfloat_batch_driver;
   localparam int TMO = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b1;
   logic        i_wr_en = 1'b0;
   logic [2:0]  i_wr_addr = '0;
   logic [31:0] i_wr_data = '0;
   logic [3:0]  i_count = '0;
   logic        i_start = 1'b0;
   logic        o_busy, o_done, o_error;
   logic [2:0]  i_rd_addr = '0;
   logic [31:0] o_rd_data;
   logic        o_div_req;
   logic [31:0] o_div_input_a;
   logic        i_div_busy;
   logic [31:0] i_div_return;

   divfloat_batch_driver #(.DEPTH(8), .ADDR_W(3), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .ce(ce),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_count(i_count), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
      .o_div_req(o_div_req), .o_div_input_a(o_div_input_a),
      .i_div_busy(i_div_busy), .i_div_return(i_div_return)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Quotient reference: the three known divide-by-1.3 pairs, otherwise an arbitrary bijection.
   function automatic logic [31:0] div_model(input logic [31:0] a);
      case (a)
         32'h3FA66666: return 32'h3F800000;
         32'h40266666: return 32'h40000000;
         32'h00000000: return 32'h00000000;
         default:      return a ^ 32'h0055_AA00;
      endcase
   endfunction

   int          div_lat = 35;
   bit          div_stuck = 1'b0;
   logic        d_busy = 1'b0;
   logic [31:0] d_ret = '0;
   logic [31:0] d_a = '0;
   int          d_left = 0;
   always @(posedge clock) begin
      if (reset) begin
         d_busy <= 1'b0;
         d_ret  <= '0;
         d_left <= 0;
      end else if (ce) begin
         if (d_busy) begin
            if (d_left <= 1) begin
               d_busy <= 1'b0;
               d_ret  <= div_model(d_a);
            end else begin
               d_left <= d_left - 1;
            end
         end else if (o_div_req && !div_stuck) begin
            d_busy <= 1'b1;
            d_left <= div_lat;
            d_a    <= o_div_input_a;
            d_ret  <= 32'hDEADBEEF;
         end
      end
   end
   assign i_div_busy   = d_busy;
   assign i_div_return = d_ret;

   int req_total = 0, req_long = 0, done_total = 0, busy_cyc = 0;
   logic req_prev = 1'b0;
   always @(negedge clock) begin
      if (o_div_req) begin
         req_total <= req_total + 1;
         if (req_prev) req_long <= req_long + 1;
      end
      req_prev <= o_div_req;
      if (o_done) done_total <= done_total + 1;
      if (o_busy) busy_cyc <= busy_cyc + 1;
   end

   logic [31:0] op_shadow [8];
   logic [31:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic write_op(input int addr, input logic [31:0] data);
      @(negedge clock);
      i_wr_en = 1'b1;
      i_wr_addr = 3'(addr);
      i_wr_data = data;
      op_shadow[addr] = data;
      @(negedge clock);
      i_wr_en = 1'b0;
   endtask

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) sb.push_back(div_model(op_shadow[i]));
   endtask

   task automatic read_check(input int n, input string tag);
      logic [31:0] exp;
      for (int i = 0; i < n; i++) begin
         i_rd_addr = 3'(i);
         #1;
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            exp = sb.pop_front();
            check($sformatf("%s_res%0d", tag, i), o_rd_data, exp);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      i_start = 1'b0;
      i_wr_en = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   // Start a batch at a negedge and wait (bounded) for done; delay counts edges from the start edge.
   task automatic do_run(input logic [3:0] cnt, input int max_cyc, input int stall_at,
                         input int poke_at, output int delay, output bit got);
      int t0;
      @(negedge clock);
      t0 = cyc;
      i_count = cnt;
      i_start = 1'b1;
      got = 1'b0;
      delay = 0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clock);
         i_start = 1'b0;
         i_wr_en = 1'b0;
         if (o_done) begin
            got = 1'b1;
            delay = cyc - t0;
            break;
         end
         if (k == poke_at) begin
            i_start = 1'b1;
            i_wr_en = 1'b1;
            i_wr_addr = 3'd0;
            i_wr_data = 32'hBAD0_BAD0;
         end
         if (k == stall_at) ce = 1'b0;
         if (k == stall_at + 10) ce = 1'b1;
      end
      ce = 1'b1;
      @(negedge clock);
   endtask

   typedef struct {
      logic [3:0]        count;
      logic [7:0][31:0]  ops;
      int                lat;
      int                nreq;
   } vec_t;

   initial begin
      vec_t vt [4];
      int   r0, l0, d0, b0, delay, d_ref;
      bit   got;

      vt[0].count = 4'd3; vt[0].lat = 35; vt[0].nreq = 3; vt[0].ops = '0;
      vt[0].ops[0] = 32'h3FA66666; vt[0].ops[1] = 32'h40266666; vt[0].ops[2] = 32'h00000000;
      vt[1].count = 4'd1; vt[1].lat = 3;  vt[1].nreq = 1; vt[1].ops = '0;
      vt[1].ops[0] = 32'h40A00000;
      vt[2].count = 4'd8; vt[2].lat = 1;  vt[2].nreq = 8;
      vt[3].count = 4'd5; vt[3].lat = 7;  vt[3].nreq = 5;
      for (int i = 0; i < 8; i++) begin
         vt[2].ops[i] = 32'h1000_0000 + 32'h0111_1111 * i;
         vt[3].ops[i] = 32'hC000_0001 + 32'h0023_4567 * i;
      end

      repeat (3) @(negedge clock);
      reset = 1'b0;
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_req", o_div_req, 0);
      check("rst_input_a", o_div_input_a, 0);
      check("rst_error", o_error, 0);

      for (int v = 0; v < 4; v++) begin
         div_lat = vt[v].lat;
         for (int i = 0; i < 8; i++) write_op(i, vt[v].ops[i]);
         push_exp(vt[v].nreq);
         r0 = req_total; l0 = req_long; d0 = done_total;
         do_run(vt[v].count, 2000, -1, -1, delay, got);
         check($sformatf("v%0d_done_seen", v), got, 1);
         check($sformatf("v%0d_req_count", v), req_total - r0, vt[v].nreq);
         check($sformatf("v%0d_req_single", v), req_long - l0, 0);
         check($sformatf("v%0d_done_count", v), done_total - d0, 1);
         check($sformatf("v%0d_error", v), o_error, 0);
         check($sformatf("v%0d_busy_after", v), o_busy, 0);
         read_check(vt[v].nreq, $sformatf("v%0d", v));
      end

      // Zero count: done two edges after start, busy for two cycles, no request.
      r0 = req_total; d0 = done_total; b0 = busy_cyc;
      do_run(4'd0, 50, -1, -1, delay, got);
      check("zero_done_seen", got, 1);
      check("zero_done_delay", delay, 2);
      check("zero_no_req", req_total - r0, 0);
      check("zero_busy_cycles", busy_cyc - b0, 2);
      check("zero_done_count", done_total - d0, 1);

      // Over-range count with a start and a write poked in mid-run.
      div_lat = 35;
      for (int i = 0; i < 8; i++) write_op(i, 32'h3300_0000 + 32'h0001_0203 * i);
      push_exp(8);
      r0 = req_total; d0 = done_total;
      do_run(4'd15, 2000, -1, 5, delay, got);
      check("ovr_done_seen", got, 1);
      check("ovr_req_count", req_total - r0, 8);
      check("ovr_done_count", done_total - d0, 1);
      read_check(8, "ovr");
      push_exp(1);
      do_run(4'd1, 200, -1, -1, delay, got);
      check("ovr_op0_done", got, 1);
      read_check(1, "ovr_op0");

      // CE stall of 10 cycles inside WAIT_DONE shifts done by exactly 10.
      write_op(0, 32'h3FA66666);
      write_op(1, 32'h40266666);
      push_exp(2);
      do_run(4'd2, 500, -1, -1, d_ref, got);
      check("ce_ref_done", got, 1);
      read_check(2, "ce_ref");
      push_exp(2);
      do_run(4'd2, 500, 10, -1, delay, got);
      check("ce_stall_done", got, 1);
      check("ce_stall_delta", delay - d_ref, 10);
      read_check(2, "ce_stall");

      // Watchdog: divider never acknowledges.
      div_stuck = 1'b1;
`ifdef DIVBATCH_TIMEOUT_EN
      d0 = done_total;
      do_run(4'd2, 300, -1, -1, delay, got);
      check("wd_done_seen", got, 1);
      check("wd_delay_window", (delay >= TMO) && (delay <= TMO + 8), 1);
      check("wd_error_set", o_error, 1);
      check("wd_done_count", done_total - d0, 1);
      div_stuck = 1'b0;
      push_exp(1);
      do_run(4'd1, 200, -1, -1, delay, got);
      check("wd_rerun_done", got, 1);
      check("wd_error_cleared", o_error, 0);
      read_check(1, "wd_rerun");
`else
      do_run(4'd2, 300, -1, -1, delay, got);
      check("nowd_no_done", got, 0);
      check("nowd_busy_held", o_busy, 1);
      check("nowd_error_zero", o_error, 0);
      div_stuck = 1'b0;
      do_reset();
`endif

      // Reset during element 2 of 4, then a clean rerun.
      for (int i = 0; i < 4; i++) write_op(i, 32'h4100_0000 + 32'h0000_1111 * i);
      r0 = req_total; d0 = done_total;
      @(negedge clock);
      i_count = 4'd4;
      i_start = 1'b1;
      @(negedge clock);
      i_start = 1'b0;
      for (int k = 0; k < 500 && (req_total - r0) < 2; k++) @(negedge clock);
      check("mrst_reached_elem2", req_total - r0, 2);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mrst_busy", o_busy, 0);
      check("mrst_done", o_done, 0);
      check("mrst_req", o_div_req, 0);
      check("mrst_input_a", o_div_input_a, 0);
      check("mrst_error", o_error, 0);
      check("mrst_no_done_pulse", done_total - d0, 0);
      push_exp(4);
      do_run(4'd4, 1000, -1, -1, delay, got);
      check("mrst_rerun_done", got, 1);
      read_check(4, "mrst_rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
